mmd_counter: RTL and testbench

//   Programmable counter-based divider, downstream of the MASH 1-1-1 modulator top.

---
 rtl/dsm_pkg.sv | 12 +
 rtl/div_clamp.sv | 27 ++
 rtl/mmd_counter.sv | 106 ++++++++++
 tb/tb_mmd_counter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared constants and FSM encoding for the MASH divider chain.
package dsm_pkg;
  localparam int DIV_W   = 4;
  localparam int MIN_DIV = 3;
  localparam int MAX_DIV = 11;
  localparam int CNT_W   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/div_clamp.sv
// Clamps the modulator ratio into [MIN_DIV, MAX_DIV] and flags out-of-range input.
module div_clamp
  import dsm_pkg::*;
#(
  parameter int P_DIV_W   = DIV_W,
  parameter int P_MIN_DIV = MIN_DIV,
  parameter int P_MAX_DIV = MAX_DIV
) (
  input  logic [P_DIV_W-1:0] div_in,
  output logic [P_DIV_W-1:0] ratio,
  output logic               out_of_range
);
  localparam logic [P_DIV_W-1:0] MIN_V = P_DIV_W'(P_MIN_DIV);
  localparam logic [P_DIV_W-1:0] MAX_V = P_DIV_W'(P_MAX_DIV);

  always_comb begin
    ratio        = div_in;
    out_of_range = 1'b0;
    if (div_in < MIN_V) begin
      ratio        = MIN_V;
      out_of_range = 1'b1;
    end else if (div_in > MAX_V) begin
      ratio        = MAX_V;
      out_of_range = 1'b1;
    end
  end
endmodule

// File: rtl/mmd_counter.sv
// Programmable down-counter divider: one clamped ratio per output period,
// registered divided clock with high phase of ceil(N/2) cycles.
module mmd_counter
  import dsm_pkg::*;
#(
  parameter int P_DIV_W   = DIV_W,
  parameter int P_MIN_DIV = MIN_DIV,
  parameter int P_MAX_DIV = MAX_DIV,
  parameter int P_CNT_W   = CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [P_DIV_W-1:0] div_in,
  input  logic               clr_err,
  output logic               div_clk,
  output logic               tc_pulse,
  output logic               div_take,
  output logic               busy,
  output logic               clamp_err,
  output logic [P_CNT_W-1:0] period_cnt
);
  // Handshake: div_in is consumed in any cycle where div_take is high; the
  // upstream ratio must be stable for that whole cycle. There is no back-pressure.

  state_t               state_q, state_d;
  logic [P_DIV_W-1:0]   cnt_q, cnt_d;
  logic [P_DIV_W-1:0]   ratio_q, ratio_d;
  logic                 div_clk_q, tc_q, clamp_q;
  logic [P_CNT_W-1:0]   period_q;
  logic [P_DIV_W-1:0]   n_clamped;
  logic                 n_oor;
  logic                 take;
  logic                 div_clk_d, tc_d;

  div_clamp #(
    .P_DIV_W  (P_DIV_W),
    .P_MIN_DIV(P_MIN_DIV),
    .P_MAX_DIV(P_MAX_DIV)
  ) u_clamp (
    .div_in      (div_in),
    .ratio       (n_clamped),
    .out_of_range(n_oor)
  );

  assign take = en && ((state_q == IDLE) || (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          cnt_d   = n_clamped - P_DIV_W'(1);
          ratio_d = n_clamped;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - P_DIV_W'(1);
        end else if (en) begin
          cnt_d   = n_clamped - P_DIV_W'(1);
          ratio_d = n_clamped;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are computed from next-state so the registered versions line up
    // with the cycle they describe.
    tc_d      = (state_d == RUN) && (cnt_d == '0);
    div_clk_d = (state_d == RUN) && (cnt_d >= (ratio_d >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ratio_q   <= '0;
      div_clk_q <= 1'b0;
      tc_q      <= 1'b0;
      clamp_q   <= 1'b0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      div_clk_q <= div_clk_d;
      tc_q      <= tc_d;
      if (take && n_oor) clamp_q <= 1'b1;
      else if (clr_err)  clamp_q <= 1'b0;
      // tc_q is high exactly in the last cycle of a period, so this edge closes it.
      if (tc_q) period_q <= period_q + P_CNT_W'(1);
    end
  end

  assign div_clk    = div_clk_q;
  assign tc_pulse   = tc_q;
  assign div_take   = take;
  assign busy       = (state_q == RUN);
  assign clamp_err  = clamp_q;
  assign period_cnt = period_q;
endmodule

// File: tb/tb_mmd_counter.sv
// Bench for mmd_counter: directed scenarios plus random traffic, checked against
// a period-level model that expands each accepted ratio into its output waveform.
module tb_mmd_counter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  div_in;
  logic        clr_err;
  logic        div_clk, tc_pulse, div_take, busy, clamp_err;
  logic [15:0] period_cnt;

  int tests = 0;
  int fails = 0;

  // Model state: per-cycle {div_clk, tc_pulse} still owed for accepted periods.
  logic [1:0]  exp_q[$];
  logic        exp_clamp;
  logic [15:0] exp_period;
  logic        last_take;

  mmd_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_in    (div_in),
    .clr_err   (clr_err),
    .div_clk   (div_clk),
    .tc_pulse  (tc_pulse),
    .div_take  (div_take),
    .busy      (busy),
    .clamp_err (clamp_err),
    .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_clamp  = 1'b0;
    exp_period = 16'd0;
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model at the edge.
  task automatic step(input logic e, input logic [3:0] d, input logic c);
    int   n;
    logic oor;
    logic exp_take;
    en = e; div_in = d; clr_err = c;
    @(negedge clk);
    exp_take = e && (exp_q.size() <= 1);
    chk("div_clk",    {31'd0, div_clk},  {31'd0, (exp_q.size() > 0) ? exp_q[0][1] : 1'b0});
    chk("tc_pulse",   {31'd0, tc_pulse}, {31'd0, (exp_q.size() > 0) ? exp_q[0][0] : 1'b0});
    chk("div_take",   {31'd0, div_take}, {31'd0, exp_take});
    chk("busy",       {31'd0, busy},     {31'd0, exp_q.size() > 0});
    chk("clamp_err",  {31'd0, clamp_err}, {31'd0, exp_clamp});
    chk("period_cnt", {16'd0, period_cnt}, {16'd0, exp_period});
    @(posedge clk);
    if (exp_q.size() > 0) begin
      if (exp_q[0][0]) exp_period = exp_period + 16'd1;
      void'(exp_q.pop_front());
    end
    oor = (d < 4'd3) || (d > 4'd11);
    if (exp_take && oor) exp_clamp = 1'b1;
    else if (c)          exp_clamp = 1'b0;
    if (exp_take) begin
      n = (d < 4'd3) ? 3 : (d > 4'd11) ? 11 : int'(d);
      for (int i = 0; i < n; i++)
        exp_q.push_back({(i < (n + 1) / 2), (i == n - 1)});
    end
    last_take = exp_take;
    #1;
  endtask

  task automatic run_takes(input logic [3:0] d, input int k, input logic c);
    int got = 0;
    for (int i = 0; i < 12 * k + 2 && got < k; i++) begin
      step(1'b1, d, c);
      if (last_take) got++;
    end
    chk("take_budget", got, k);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; div_in = 4'd4; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_div_clk",  {31'd0, div_clk},   32'd0);
    chk("rst_tc",       {31'd0, tc_pulse},  32'd0);
    chk("rst_busy",     {31'd0, busy},      32'd0);
    chk("rst_clamp",    {31'd0, clamp_err}, 32'd0);
    chk("rst_period",   {16'd0, period_cnt}, 32'd0);
    #1 rst_n = 1'b1;

    // Constant ratio 4 and 5.
    run_takes(4'd4, 1, 1'b0);
    repeat (12) step(1'b1, 4'd4, 1'b0);
    run_takes(4'd5, 3, 1'b0);

    // Alternating extremes.
    for (int i = 0; i < 3; i++) begin
      run_takes(4'd3, 1, 1'b0);
      run_takes(4'd11, 1, 1'b0);
    end

    // Clamp behaviour and sticky error.
    run_takes(4'd1, 1, 1'b0);
    run_takes(4'd15, 1, 1'b0);
    step(1'b1, 4'd6, 1'b1);
    run_takes(4'd6, 1, 1'b0);
    run_takes(4'd0, 1, 1'b1);
    run_takes(4'd7, 1, 1'b0);

    // Enable dropped mid-period of an N=9 period.
    run_takes(4'd9, 1, 1'b0);
    repeat (5) step(1'b1, 4'd9, 1'b0);
    repeat (12) step(1'b0, 4'd9, 1'b0);
    run_takes(4'd4, 2, 1'b0);

    // Asynchronous reset during the high phase.
    run_takes(4'd8, 1, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    #1;
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_div_clk", {31'd0, div_clk},   32'd0);
    chk("arst_tc",      {31'd0, tc_pulse},  32'd0);
    chk("arst_take",    {31'd0, div_take},  32'd0);
    chk("arst_busy",    {31'd0, busy},      32'd0);
    chk("arst_clamp",   {31'd0, clamp_err}, 32'd0);
    chk("arst_period",  {16'd0, period_cnt}, 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_takes(4'd6, 3, 1'b0);

    // Period counter wrap with clamp_err held set.
    run_takes(4'd2, 1, 1'b0);
    for (int i = 0; i < 16 && exp_q.size() > 0; i++) step(1'b0, 4'd3, 1'b0);
    force dut.period_q = 16'hFFFF;
    #1;
    release dut.period_q;
    exp_period = 16'hFFFF;
    run_takes(4'd3, 3, 1'b0);
    chk("wrap_period", {16'd0, period_cnt}, {16'd0, exp_period});

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
